// File: rtl/crack_pkg.sv
`default_nettype none
// ============================================================================
// Module      : crack_pkg
// Description : Shared types and constants for the RC4 crack result arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package crack_pkg;

  localparam int KEY_W_DEFAULT = 24;

  typedef enum logic [1:0] {
    SEARCH    = 2'd0,
    FOUND     = 2'd1,
    EXHAUSTED = 2'd2
  } arb_state_t;

  // Active-low seven-segment patterns, bit 6 = segment g
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

endpackage
`default_nettype wire

// File: rtl/key_hex_decoder.sv
`default_nettype none
// ============================================================================
// Module      : key_hex_decoder
// Description : Combinational nibble to active-low seven-segment decoder
//               (bit order gfedcba, bit 6 = g).
// Revision    : 1.0 - initial release
// ============================================================================
module key_hex_decoder (
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Map each hex digit to its lit segments
  always_comb begin
    seg = 7'h7F;
    case (nibble)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/crack_result_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : crack_result_arbiter
// Description : Watches the parallel RC4 cores, latches the first winning
//               key (lowest index on ties), broadcasts stop, measures search
//               time and drives the board display.
//               Optional macro ARB_HEX_DISPLAY_EN enables the key display;
//               without it every hex output is permanently blank.
// Revision    : 1.0 - initial release
// ============================================================================
module crack_result_arbiter
  import crack_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int KEY_W     = KEY_W_DEFAULT,
  parameter int CNT_W     = 32
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_CORES-1:0]       core_success,
  input  logic [NUM_CORES-1:0]       core_failure,
  input  logic [NUM_CORES*KEY_W-1:0] core_key,
  output logic                       stop,
  output logic                       found,
  output logic                       exhausted,
  output logic [2:0]                 winner_idx,
  output logic [KEY_W-1:0]           found_key,
  output logic [CNT_W-1:0]           elapsed,
  output logic [6:0]                 hex0,
  output logic [6:0]                 hex1,
  output logic [6:0]                 hex2,
  output logic [6:0]                 hex3,
  output logic [6:0]                 hex4,
  output logic [6:0]                 hex5
);

  logic [NUM_CORES-1:0]       succ_q, fail_q;
  logic [NUM_CORES*KEY_W-1:0] key_q;
  logic [NUM_CORES-1:0]       fail_seen_q, fail_seen_d;
  arb_state_t                 state_q, state_d;
  logic                       stop_q, stop_d;
  logic                       found_q, found_d;
  logic                       exhausted_q, exhausted_d;
  logic [2:0]                 winner_q, winner_d;
  logic [KEY_W-1:0]           found_key_q, found_key_d;
  logic [CNT_W-1:0]           elapsed_q, elapsed_d;
  logic [2:0]                 win_idx;
  logic [KEY_W-1:0]           win_key;
  logic [NUM_CORES-1:0]       fail_all;

  // Lowest-index successful core wins; scan downward so the lowest overrides
  always_comb begin
    win_idx = '0;
    win_key = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (succ_q[i]) begin
        win_idx = 3'(i);
        win_key = key_q[i*KEY_W +: KEY_W];
      end
    end
  end

  assign fail_all = fail_seen_q | fail_q;

  // Next-state logic: success beats a coincident final failure
  always_comb begin
    state_d     = state_q;
    fail_seen_d = fail_seen_q;
    winner_d    = winner_q;
    found_key_d = found_key_q;
    elapsed_d   = elapsed_q;
    if (state_q == SEARCH) begin
      fail_seen_d = fail_all;
      if (elapsed_q != {CNT_W{1'b1}}) begin
        elapsed_d = elapsed_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (|succ_q) begin
        state_d     = FOUND;
        winner_d    = win_idx;
        found_key_d = win_key;
      end else if (&fail_all) begin
        state_d = EXHAUSTED;
      end
    end
    stop_d      = (state_d != SEARCH);
    found_d     = (state_d == FOUND);
    exhausted_d = (state_d == EXHAUSTED);
  end

  // Input capture, FSM and registered status outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      succ_q      <= '0;
      fail_q      <= '0;
      key_q       <= '0;
      fail_seen_q <= '0;
      state_q     <= SEARCH;
      stop_q      <= 1'b0;
      found_q     <= 1'b0;
      exhausted_q <= 1'b0;
      winner_q    <= '0;
      found_key_q <= '0;
      elapsed_q   <= '0;
    end else begin
      succ_q      <= core_success;
      fail_q      <= core_failure;
      key_q       <= core_key;
      fail_seen_q <= fail_seen_d;
      state_q     <= state_d;
      stop_q      <= stop_d;
      found_q     <= found_d;
      exhausted_q <= exhausted_d;
      winner_q    <= winner_d;
      found_key_q <= found_key_d;
      elapsed_q   <= elapsed_d;
    end
  end

  assign stop       = stop_q;
  assign found      = found_q;
  assign exhausted  = exhausted_q;
  assign winner_idx = winner_q;
  assign found_key  = found_key_q;
  assign elapsed    = elapsed_q;

`ifdef ARB_HEX_DISPLAY_EN
  logic [23:0]     disp_key;
  logic [5:0][6:0] digit_seg;
  logic [5:0][6:0] hex_d, hex_q;

  // Display always shows six nibbles; narrow keys are zero-padded
  if (KEY_W >= 24) begin : g_key_trunc
    assign disp_key = found_key_d[23:0];
  end else begin : g_key_pad
    assign disp_key = {{(24-KEY_W){1'b0}}, found_key_d};
  end

  for (genvar d = 0; d < 6; d++) begin : g_digit
    key_hex_decoder u_dec (
      .nibble (disp_key[d*4 +: 4]),
      .seg    (digit_seg[d])
    );
  end

  // Choose digit, dash or blank from the upcoming state so hex tracks found
  always_comb begin
    for (int d = 0; d < 6; d++) begin
      case (state_d)
        FOUND:     hex_d[d] = digit_seg[d];
        EXHAUSTED: hex_d[d] = SEG_DASH;
        default:   hex_d[d] = SEG_BLANK;
      endcase
    end
  end

  // Registered display outputs, blank out of reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hex_q <= {6{SEG_BLANK}};
    end else begin
      hex_q <= hex_d;
    end
  end

  assign hex0 = hex_q[0];
  assign hex1 = hex_q[1];
  assign hex2 = hex_q[2];
  assign hex3 = hex_q[3];
  assign hex4 = hex_q[4];
  assign hex5 = hex_q[5];
`else
  assign hex0 = SEG_BLANK;
  assign hex1 = SEG_BLANK;
  assign hex2 = SEG_BLANK;
  assign hex3 = SEG_BLANK;
  assign hex4 = SEG_BLANK;
  assign hex5 = SEG_BLANK;
`endif

endmodule
`default_nettype wire

// File: doc/crack_result_arbiter.md
# crack_result_arbiter

Collects status from the parallel RC4 brute-force cores and decides the overall outcome. It sits directly downstream of the per-core `success` / `total_failure` / `secret_key` outputs. It selects the first core to report success and latches that core's key. It broadcasts `stop` back to every core and records search time. It also drives the board display with the winning key or an exhausted indication.

## Interface
Parameters:
- `NUM_CORES`, default 4: number of cracking cores monitored; legal range 1–8.
- `KEY_W`, default 24: secret key width.
- `CNT_W`, default 32: elapsed-cycle counter width.

Ports:
- `clk` (in, 1): the single clock for the block.
- `reset_n` (in, 1): reset, asynchronous, active-low. Clears every register.
- `core_success` (in, NUM_CORES): per-core success, either a pulse or a level.
- `core_failure` (in, NUM_CORES): per-core key-space exhausted, either a pulse or a level.
- `core_key` (in, NUM_CORES*KEY_W): core i's current key occupies bits [i*KEY_W +: KEY_W].
- `stop` (out, 1): broadcast halt to all cores.
- `found` (out, 1): a key was found.
- `exhausted` (out, 1): every core failed.
- `winner_idx` (out, 3): index of the winning core.
- `found_key` (out, KEY_W): latched winning key.
- `elapsed` (out, CNT_W): cycles spent in SEARCH.
- `hex0`–`hex5` (out, 7 each): active-low seven-segment outputs.

## Operation
- Input capture: `core_success`, `core_failure` and `core_key` are registered once into `succ_q`, `fail_q` and `key_q` every cycle.
- Sticky failure mask `fail_seen`: `fail_seen <= fail_seen | fail_q` while in SEARCH. This lets failure pulses accumulate across cycles.
- FSM states are SEARCH, FOUND and EXHAUSTED. Reset enters SEARCH.
  - SEARCH → FOUND when `succ_q != 0`.
    - `winner_idx` = lowest set index of `succ_q`.
    - `found_key` = that core's slice of `key_q`.
  - SEARCH → EXHAUSTED when `succ_q == 0` and `(fail_seen | fail_q)` is all ones.
  - If success and the final failure arrive in the same cycle, success wins and the FSM goes to FOUND.
  - FOUND and EXHAUSTED are terminal. They hold until `reset_n` is asserted, and ignore all inputs.
- Success from a core whose failure was already latched is still accepted.
- `stop` = 1 in FOUND and EXHAUSTED, and 0 in SEARCH. It is a registered output.
- `found` is 1 only in FOUND. `exhausted` is 1 only in EXHAUSTED. The two are never high together.
- `elapsed`:
  - Increments by 1 every cycle in SEARCH.
  - Saturates at all ones, with no wrap.
  - Freezes on leaving SEARCH.
- `found_key` and `winner_idx` are written exactly once, on the SEARCH → FOUND transition. Otherwise they hold their value (0 after reset).
- Bits of `core_key` for non-winning cores are ignored.

## Timing
- Reset values:
  - `stop`, `found`, `exhausted`, `winner_idx`, `found_key` and `elapsed` are all 0.
  - `hex0`–`hex5` are 7'h7F (blank).
- Latency, input to output:
  - An input asserted before clock edge k is captured at edge k.
  - The FSM transitions at edge k+1.
  - `stop`, `found` / `exhausted` and `found_key` are valid after edge k+1. This is 2 cycles.
  - `hex*` updates at the same edge.
- `elapsed` reports the number of SEARCH cycles, including the cycle of the transition edge.
- `reset_n` falling in any state clears all outputs immediately, without waiting for `clk`. On the first edge after release, the block is in SEARCH with `fail_seen` = 0.
- Cores must treat `stop` as a level. `stop` never deasserts except through reset.

## Configuration
- `ARB_HEX_DISPLAY_EN` defined:
  - In FOUND, `hex5`…`hex0` show `found_key` as six hex nibbles, with `hex0` = bits [3:0].
  - In EXHAUSTED, all six show "-" (7'h3F).
  - In SEARCH, all six are blank (7'h7F).
- `ARB_HEX_DISPLAY_EN` undefined:
  - No decoder is instantiated.
  - `hex0`–`hex5` are tied to 7'h7F permanently.
  - All other behaviour is identical.

## Structure
- Package `crack_pkg` contains:
  - `KEY_W_DEFAULT` (24).
  - Enum `arb_state_t` {SEARCH, FOUND, EXHAUSTED}.
  - Segment constants `SEG_BLANK` (7'h7F) and `SEG_DASH` (7'h3F).
- Sub-module `key_hex_decoder` maps a 4-bit nibble to a 7-bit active-low segment pattern. It is purely combinational and instantiated 6× under the macro. The display outputs are registered in the arbiter.

## Test plan
All scenarios use NUM_CORES=4 and `ARB_HEX_DISPLAY_EN` defined.
- Reset: hold `reset_n`=0 for 3 cycles → all outputs 0, every `hex*` = 7'h7F, and `elapsed` counts from 0 after release.
- Single success: at cycle 10 pulse `core_success`[2] with core 2 key = 24'h0B3C1A.
  - 2 cycles later: `found`=1, `stop`=1, `winner_idx`=2, `found_key`=24'h0B3C1A.
  - `hex5`..`hex0` display 0,B,3,C,1,A.
  - `elapsed` stays frozen afterwards.
- Simultaneous success: `core_success`=4'b1010 in one cycle → `winner_idx`=1 and `found_key` = core 1's key.
- Exhaustion via pulses: pulse `core_failure` bits 0,1,2,3 at cycles 5, 9, 20 and 31.
  - `exhausted`=0 until bit 3 arrives.
  - `exhausted`=1 and `stop`=1 at cycle 33; `found` stays 0 and hex shows all dashes.
- Tie: `fail_seen`=4'b0111, then `core_failure`[3] and `core_success`[3] pulse in the same cycle → `found`=1, `exhausted`=0, `winner_idx`=3.
- Reset mid-result: while in FOUND, drive `reset_n` low between clock edges → outputs clear asynchronously, and after release a new success is accepted normally.
